// File: rtl/tx_sched_pkg.sv
// Shared tx definitions: tx core event codes plus scheduler state encodings and frame limits.
package tx_sched_pkg;

  // Event codes reported by the tx core on i_tx_ev when i_tx_ev_sig strobes.
  localparam logic [2:0] TX_EVENT_NONE = 3'd0;
  localparam logic [2:0] TX_EVENT_SFD  = 3'd1;
  localparam logic [2:0] TX_EVENT_END  = 3'd2;

  localparam logic [2:0] TX_SCHED_STATE_IDLE     = 3'd0;
  localparam logic [2:0] TX_SCHED_STATE_ARB      = 3'd1;
  localparam logic [2:0] TX_SCHED_STATE_LOAD_LEN = 3'd2;
  localparam logic [2:0] TX_SCHED_STATE_LOAD     = 3'd3;
  localparam logic [2:0] TX_SCHED_STATE_START    = 3'd4;
  localparam logic [2:0] TX_SCHED_STATE_TX       = 3'd5;
  localparam logic [2:0] TX_SCHED_STATE_GAP      = 3'd6;

  localparam int TX_FCS_LEN     = 2;
  localparam int TX_MAX_PAYLOAD = 125;

  typedef enum logic [2:0] {
    ST_IDLE     = TX_SCHED_STATE_IDLE,
    ST_ARB      = TX_SCHED_STATE_ARB,
    ST_LOAD_LEN = TX_SCHED_STATE_LOAD_LEN,
    ST_LOAD     = TX_SCHED_STATE_LOAD,
    ST_START    = TX_SCHED_STATE_START,
    ST_TX       = TX_SCHED_STATE_TX,
    ST_GAP      = TX_SCHED_STATE_GAP
  } sched_state_t;

endpackage

// File: rtl/tx_sched_if.sv
// Requester, TX buffer and tx core signals of the frame scheduler.
interface tx_sched_if #(parameter int N = 2);
  logic [N-1:0]   i_req;
  logic [7*N-1:0] i_len;
  logic [N-1:0]   o_grant;
  logic [6:0]     o_rd_addr;
  logic [8*N-1:0] i_rd_data;
  logic [N-1:0]   o_done;
  logic           o_err;
  logic           o_buf_w_en;
  logic [6:0]     o_buf_w_addr;
  logic [7:0]     o_buf_byte;
  logic           o_tx_start;
  logic [2:0]     i_tx_ev;
  logic           i_tx_ev_sig;
  logic           o_busy;

  modport master (
    output i_req, i_len, i_rd_data, i_tx_ev, i_tx_ev_sig,
    input  o_grant, o_rd_addr, o_done, o_err, o_buf_w_en, o_buf_w_addr,
           o_buf_byte, o_tx_start, o_busy
  );

  modport slave (
    input  i_req, i_len, i_rd_data, i_tx_ev, i_tx_ev_sig,
    output o_grant, o_rd_addr, o_done, o_err, o_buf_w_en, o_buf_w_addr,
           o_buf_byte, o_tx_start, o_busy
  );
endinterface

// File: rtl/tx_sched_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping to 0.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             vld
);

  always_comb begin : pick
    logic [IDX_W-1:0] pos;
    grant = '0;
    idx   = '0;
    vld   = 1'b0;
    pos   = '0;
    for (int i = 0; i < N; i++) begin
      pos = IDX_W'((int'(ptr) + i) % N);
      if (!vld && req[pos]) begin
        vld        = 1'b1;
        grant[pos] = 1'b1;
        idx        = pos;
      end
    end
  end

endmodule

// File: rtl/tx_sched.sv
// Frame scheduler: round-robin over N requesters, copies length byte + payload into
// the TX buffer, starts the tx core, waits for END (with watchdog) and an inter-frame gap.
module tx_sched
  import tx_sched_pkg::*;
#(
  parameter int          N       = 2,
  parameter logic [31:0] GAP_CNT = 32'd2000,
  parameter logic [31:0] TIMEOUT = 32'd4000000
) (
  input  logic     clk,
  input  logic     reset,
  tx_sched_if.slave bus
);

  localparam int IDX_W = $clog2(N);

  sched_state_t     state;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] win;
  logic [6:0]       len;
  logic [31:0]      cnt;
  logic             err_flag;

  logic [N-1:0]     arb_grant;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_vld;
  logic [6:0]       arb_len;
  logic [7:0]       rd_byte;

  rr_arbiter #(.N(N), .IDX_W(IDX_W)) u_arb (
    .req   (bus.i_req),
    .ptr   (ptr),
    .grant (arb_grant),
    .idx   (arb_idx),
    .vld   (arb_vld)
  );

  assign arb_len    = bus.i_len[7*arb_idx +: 7];
  assign rd_byte    = bus.i_rd_data[8*win +: 8];
  assign bus.o_busy = (state != ST_IDLE);

  // Outputs are registered on the transition into the state they belong to, so the
  // buffer write of address k appears one cycle after the FSM sampled its byte.
  // GAP_CNT must be at least 2: the END/timeout cycle counts as the first gap cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= ST_IDLE;
      ptr              <= '0;
      win              <= '0;
      len              <= '0;
      cnt              <= '0;
      err_flag         <= 1'b0;
      bus.o_grant      <= '0;
      bus.o_rd_addr    <= '0;
      bus.o_done       <= '0;
      bus.o_err        <= 1'b0;
      bus.o_buf_w_en   <= 1'b0;
      bus.o_buf_w_addr <= '0;
      bus.o_buf_byte   <= '0;
      bus.o_tx_start   <= 1'b0;
    end else begin
      bus.o_done     <= '0;
      bus.o_err      <= 1'b0;
      bus.o_buf_w_en <= 1'b0;
      bus.o_tx_start <= 1'b0;
      case (state)
        ST_IDLE: if (|bus.i_req) state <= ST_ARB;
        ST_ARB: begin
          if (!arb_vld) begin
            state <= ST_IDLE;
          end else begin
            ptr <= (arb_idx == IDX_W'(N-1)) ? '0 : arb_idx + 1'b1;
            win <= arb_idx;
            len <= arb_len;
            if (arb_len > 7'(TX_MAX_PAYLOAD)) begin
              bus.o_done <= arb_grant;
              bus.o_err  <= 1'b1;
              state      <= ST_IDLE;
            end else begin
              bus.o_grant   <= arb_grant;
              bus.o_rd_addr <= '0;
              state         <= ST_LOAD_LEN;
            end
          end
        end
        ST_LOAD_LEN: begin
          bus.o_buf_w_en   <= 1'b1;
          bus.o_buf_w_addr <= '0;
          bus.o_buf_byte   <= {1'b0, len} + 8'(TX_FCS_LEN);
          cnt              <= '0;
          if (len == 7'd0) begin
            state <= ST_START;
          end else begin
            bus.o_rd_addr <= 7'd1;
            state         <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          bus.o_buf_w_en   <= 1'b1;
          bus.o_buf_w_addr <= 7'(cnt + 32'd1);
          bus.o_buf_byte   <= rd_byte;
          bus.o_rd_addr    <= 7'(cnt + 32'd2);
          cnt              <= cnt + 32'd1;
          if (cnt + 32'd1 == {25'd0, len}) state <= ST_START;
        end
        ST_START: begin
          bus.o_tx_start <= 1'b1;
          cnt            <= '0;
          err_flag       <= 1'b0;
          state          <= ST_TX;
        end
        ST_TX: begin
          if (bus.i_tx_ev_sig && bus.i_tx_ev == TX_EVENT_END) begin
            cnt   <= 32'd1;
            state <= ST_GAP;
          end else if (cnt == TIMEOUT) begin
            err_flag <= 1'b1;
            cnt      <= 32'd1;
            state    <= ST_GAP;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        ST_GAP: begin
          if (cnt == GAP_CNT - 32'd1) begin
            bus.o_done  <= bus.o_grant;
            bus.o_err   <= err_flag;
            bus.o_grant <= '0;
            state       <= ST_IDLE;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/tx_sched.md
Name: tx_sched

Overview:
- Frame scheduler in front of the `tx` core: N requesters share one TX buffer and TX engine.
- Picks a requester by round-robin and copies its payload into the TX buffer, prefixed by the length byte.
- Pulses `tx` start, waits for TX_EVENT_END, enforces an inter-frame gap, then acknowledges the requester.
- A watchdog aborts a transmission that never reports END.

Parameters:
- N, 2, number of requesters (≥2).
- GAP_CNT, 32'd2000, idle cycles after each frame (100 us at 20 MHz).
- TIMEOUT, 32'd4000000, max cycles in TX waiting for END (200 ms at 20 MHz).

Ports:
- clk  in  1  clock
- reset  in  1  sync reset, active-high
- i_req  in  N  per-requester frame request, level, held until o_done[i]
- i_len  in  7*N  payload length of requester i in bits [7i+6:7i], bytes
- o_grant  out  N  one-hot, requester currently being served
- o_rd_addr  out  7  payload byte index requested from granted requester
- i_rd_data  in  8*N  payload byte of requester i, valid 1 cycle after o_rd_addr
- o_done  out  N  one-hot 1-cycle acknowledge at end of service
- o_err  out  1  1-cycle pulse together with o_done on reject/timeout
- o_buf_w_en  out  1  TX buffer write enable
- o_buf_w_addr  out  7  TX buffer write address
- o_buf_byte  out  8  TX buffer write data
- o_tx_start  out  1  1-cycle start pulse to `tx`
- i_tx_ev  in  3  `tx` event code
- i_tx_ev_sig  in  1  `tx` event strobe
- o_busy  out  1  high in any state but IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, RR pointer 0, counters 0. Reset mid-frame abandons it silently: no o_done, buffer contents undefined. `tx` shares the same reset.
- IDLE: if |i_req, go to ARB next cycle.
- ARB (1 cycle):
  - Pick the first requester with i_req set, searching from the RR pointer upward with wrap.
  - Set o_grant and latch its length L. Pointer becomes winner+1 mod N.
  - If L>125: o_done[w]=1 and o_err=1 for 1 cycle, clear o_grant, go to IDLE. Buffer is not written.
  - Otherwise go to LOAD_LEN.
- LOAD_LEN (1 cycle):
  - Write buffer address 0 with L+2 (2-byte FCS appended by `tx`).
  - Drive o_rd_addr=0.
  - If L=0 go to START, else go to LOAD.
- LOAD:
  - Cycle k (k=0..L-1) writes buffer address k+1 with i_rd_data[8w+7:8w] and drives o_rd_addr=k+1.
  - After writing address L: o_buf_w_en=0, go to START.
  - Total load time is L+1 cycles including LOAD_LEN.
- START: o_tx_start=1 for exactly 1 cycle, clear watchdog, go to TX.
- TX:
  - Ignore events other than TX_EVENT_END; SFD is allowed and ignored.
  - On i_tx_ev_sig with END: go to GAP.
  - If the watchdog reaches TIMEOUT without END: set the error flag and go to GAP.
- GAP:
  - Count GAP_CNT cycles, then pulse o_done[w] for 1 cycle (plus o_err if flagged), clear o_grant, go to IDLE.
  - A requester's i_req is sampled again no earlier than the cycle after o_done.
- i_req deassertion while granted: the frame still completes; the requester must not change i_len or payload while granted.
- END arriving in the same cycle as TIMEOUT: END wins, no error.
- Counters are 32-bit. Comparisons use ==, with no wrap possible inside bounds.
- o_buf_w_addr/o_buf_byte hold their last value when o_buf_w_en=0.

Decomposition:
- TX_EVENT_* codes come from the shared tx header; do not redefine them.
- Add to that header: TX_SCHED_STATE_* encodings (3 bits: IDLE, ARB, LOAD_LEN, LOAD, START, TX, GAP) and TX_FCS_LEN=2, TX_MAX_PAYLOAD=125.
- One sub-module: rr_arbiter (N-bit request, pointer in, one-hot grant and index out, combinational) so it can be reused by the RX side.

Test Plan:
- i_req=01, L=4, payload 11 22 33 44 -> buffer writes {0:06,1:11,2:22,3:33,4:44}; one o_tx_start 1 cycle after the last write; o_done=01 exactly GAP_CNT cycles after END.
- i_req=11 held continuously, both L=1 -> grants alternate 01,10,01,10; no requester served twice in a row.
- i_req=01 with L=0 -> single write {0:02}, start pulse, normal o_done; L=126 -> o_done=01 and o_err=1 in cycle after ARB, no buffer write, no start.
- No END after start (TIMEOUT=100 in bench) -> after 100 TX cycles plus GAP_CNT: o_done and o_err pulse; next request served normally.
- reset asserted during LOAD and during TX -> next cycle all outputs 0 and o_busy=0; subsequent request with L=2 completes correctly, RR pointer restarted at 0.
